// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers host writes and launches one byte per
// transmitter busy period over a wrEn/din/busy handshake, flagging rise timeouts.
module uart_tx_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AW           = $clog2(DEPTH),
    parameter int unsigned RISE_TIMEOUT = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrEn,
    input  logic [7:0]    din,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clrErr,
    output logic          txWrEn,
    output logic [7:0]    txDin,
    input  logic          txBusy,
    output logic          txErr
);

    localparam int unsigned TW = $clog2(RISE_TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT    = DEPTH[AW:0];
    localparam logic [TW-1:0] TIMEOUT_VAL = RISE_TIMEOUT[TW-1:0];

    typedef enum logic [1:0] {
        StIdle,
        StWaitRise,
        StWaitFall
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          tx_err_q, tx_err_d;
    logic          tx_wr_en_q, tx_wr_en_d;
    logic [7:0]    tx_din_q, tx_din_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    mem_q [DEPTH];

    logic push;
    logic pop;
    logic timeout;

    // Full is judged on the registered (pre-edge) count, so a same-cycle pop never rescues a write.
    assign push = wrEn && !full_q;
    assign pop  = (state_q == StIdle) && !empty_q && !txBusy;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tx_wr_en_d = 1'b0;
        tx_din_d   = tx_din_q;
        timeout    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    tx_din_d   = mem_q[rd_ptr_q];
                    tx_wr_en_d = 1'b1;
                    timer_d    = '0;
                    state_d    = StWaitRise;
                end
            end
            StWaitRise: begin
                if (txBusy) begin
                    state_d = StWaitFall;
                end else begin
                    timer_d = timer_q + 1'b1;
                    // The byte is already popped; a timeout abandons it rather than retrying.
                    if (timer_d == TIMEOUT_VAL) begin
                        timeout = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWaitFall: begin
                if (!txBusy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d     = (count_d == FULL_CNT);
        empty_d    = (count_d == '0);
        // Set beats clear when both land on the same edge.
        overflow_d = (overflow_q && !clrErr) || (wrEn && full_q);
        tx_err_d   = (tx_err_q && !clrErr) || timeout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_err_q   <= 1'b0;
            tx_wr_en_q <= 1'b0;
            tx_din_q   <= 8'h00;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_err_q   <= tx_err_d;
            tx_wr_en_q <= tx_wr_en_d;
            tx_din_q   <= tx_din_d;
            timer_q    <= timer_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign txErr    = tx_err_q;
    assign txWrEn   = tx_wr_en_q;
    assign txDin    = tx_din_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo against a simple transmitter model whose busy
// rises two cycles after an accepted launch and stays high for one 10-bit frame.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH        = 16;
    localparam int unsigned AW           = 4;
    localparam int unsigned RISE_TIMEOUT = 7;
    localparam int          CLKS_PER_BIT = 4;
    localparam int          FRAME        = 10 * CLKS_PER_BIT;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wrEn = 1'b0;
    logic          clrErr = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          txWrEn;
    logic [7:0]    txDin;
    logic          txBusy;
    logic          txErr;

    logic       force_busy = 1'b0;
    logic       rise_en = 1'b1;
    logic       pend_q = 1'b0;
    logic       prev_wr = 1'b0;
    int         busy_cnt = 0;
    int         n_launch = 0;
    int         n_bad = 0;
    int         n_double = 0;
    logic [7:0] rx_q [$];

    int n_chk = 0;
    int n_pass = 0;

    uart_tx_fifo #(
        .DEPTH        (DEPTH),
        .AW           (AW),
        .RISE_TIMEOUT (RISE_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wrEn     (wrEn),
        .din      (din),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .clrErr   (clrErr),
        .txWrEn   (txWrEn),
        .txDin    (txDin),
        .txBusy   (txBusy),
        .txErr    (txErr)
    );

    always #5 clk = ~clk;

    assign txBusy = force_busy || (busy_cnt > 0);

    // Transmitter model and launch monitor.
    always @(posedge clk) begin
        if (txWrEn === 1'b1) begin
            n_launch++;
            if (txBusy) n_bad++;
            if (prev_wr) n_double++;
            if (rise_en) rx_q.push_back(txDin);
        end
        prev_wr <= (txWrEn === 1'b1);
        pend_q  <= (txWrEn === 1'b1) && rise_en;
        if (pend_q) busy_cnt <= FRAME;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int stable = 0;
        int n = 0;
        while (stable < 4 && n < max_cyc) begin
            tick();
            n++;
            if (empty && !txBusy && !txWrEn) stable++;
            else stable = 0;
        end
        check(tag, 32'(stable >= 4), 1);
    endtask

    initial begin
        int base;
        int launches;
        int mism;
        int n;

        // Reset state
        repeat (2) tick();
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_txerr", txErr, 0);
        check("rst_txwren", txWrEn, 0);
        check("rst_txdin", txDin, 8'h00);
        rst = 1'b1;
        repeat (2) tick();

        // Single byte: count visible one edge after the write, launch on the next
        base = rx_q.size();
        wrEn = 1'b1; din = 8'hA5;
        tick();
        wrEn = 1'b0;
        check("single_cnt1", count, 1);
        check("single_nolaunch", txWrEn, 0);
        tick();
        check("single_wren", txWrEn, 1);
        check("single_din", txDin, 8'hA5);
        check("single_cnt0", count, 0);
        check("single_empty", empty, 1);
        tick();
        check("single_pulse", txWrEn, 0);
        check("single_hold", txDin, 8'hA5);
        wait_idle("single_idle", 200);
        check("single_rx_n", rx_q.size() - base, 1);
        check("single_rx", rx_q[base], 8'hA5);

        // Burst order
        base = rx_q.size();
        for (int i = 1; i <= 5; i++) begin
            wrEn = 1'b1; din = 8'(i);
            tick();
        end
        wrEn = 1'b0;
        wait_idle("burst_idle", 1000);
        check("burst_n", rx_q.size() - base, 5);
        for (int i = 0; i < 5; i++) check("burst_order", rx_q[base + i], i + 1);

        // Full and overflow with transmitter held busy
        force_busy = 1'b1;
        base = rx_q.size();
        for (int i = 0; i < 16; i++) begin
            wrEn = 1'b1; din = 8'(8'h10 + i);
            tick();
        end
        wrEn = 1'b0;
        check("ovf_full", full, 1);
        check("ovf_count16", count, 16);
        check("ovf_pre", overflow, 0);
        wrEn = 1'b1; din = 8'hFF;
        tick();
        wrEn = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_count_kept", count, 16);
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        check("ovf_clr", overflow, 0);
        force_busy = 1'b0;
        wait_idle("ovf_drain_idle", 2500);
        check("ovf_drain_n", rx_q.size() - base, 16);
        mism = 0;
        for (int i = 0; i < 16; i++) if (rx_q[base + i] !== 8'(8'h10 + i)) mism++;
        check("ovf_drain_data", mism, 0);

        // Simultaneous write and pop at count 1
        force_busy = 1'b1;
        base = rx_q.size();
        wrEn = 1'b1; din = 8'h21;
        tick();
        wrEn = 1'b0;
        check("sim_pre_cnt", count, 1);
        force_busy = 1'b0;
        wrEn = 1'b1; din = 8'h22;
        tick();
        wrEn = 1'b0;
        check("sim_cnt", count, 1);
        check("sim_wren", txWrEn, 1);
        check("sim_din", txDin, 8'h21);
        wait_idle("sim_idle", 500);
        check("sim_rx_n", rx_q.size() - base, 2);
        check("sim_rx0", rx_q[base], 8'h21);
        check("sim_rx1", rx_q[base + 1], 8'h22);

        // Wrap: 40 bytes through the 16-entry FIFO
        base = rx_q.size();
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (full && n < 200) begin
                wrEn = 1'b0;
                tick();
                n++;
            end
            wrEn = 1'b1; din = 8'(8'h40 + i);
            tick();
        end
        wrEn = 1'b0;
        wait_idle("wrap_idle", 5000);
        check("wrap_n", rx_q.size() - base, 40);
        mism = 0;
        for (int i = 0; i < 40; i++) if (rx_q[base + i] !== 8'(8'h40 + i)) mism++;
        check("wrap_data", mism, 0);
        check("wrap_no_ovf", overflow, 0);

        // Rise timeout: transmitter never goes busy
        rise_en = 1'b0;
        wrEn = 1'b1; din = 8'h3C;
        tick();
        din = 8'h3D;
        tick();
        wrEn = 1'b0;
        check("to_wren", txWrEn, 1);
        check("to_din", txDin, 8'h3C);
        check("to_cnt", count, 1);
        repeat (6) tick();
        check("to_err_early", txErr, 0);
        tick();
        check("to_err_set", txErr, 1);
        check("to_no_relaunch", txWrEn, 0);
        tick();
        check("to_next_wren", txWrEn, 1);
        check("to_next_din", txDin, 8'h3D);
        repeat (8) tick();
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        check("to_err_clr", txErr, 0);
        rise_en = 1'b1;

        // Async reset during WAIT_FALL with 3 bytes queued
        for (int i = 0; i < 4; i++) begin
            wrEn = 1'b1; din = 8'(8'h50 + i);
            tick();
        end
        wrEn = 1'b0;
        n = 0;
        while (!txBusy && n < 20) begin
            tick();
            n++;
        end
        check("ar_busy_seen", txBusy, 1);
        tick();
        check("ar_pre_cnt", count, 3);
        launches = n_launch;
        #2;
        rst = 1'b0;
        #1;
        check("ar_empty", empty, 1);
        check("ar_count", count, 0);
        check("ar_txwren", txWrEn, 0);
        check("ar_full", full, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (60) tick();
        check("ar_no_launch", n_launch - launches, 0);
        base = rx_q.size();
        wrEn = 1'b1; din = 8'h77;
        tick();
        wrEn = 1'b0;
        wait_idle("ar_new_idle", 300);
        check("ar_new_n", rx_q.size() - base, 1);
        check("ar_new_rx", rx_q[base], 8'h77);

        // Handshake sanity across the whole run
        check("never_launch_busy", n_bad, 0);
        check("pulse_one_cycle", n_double, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
